// File: rtl/mc_control.sv
// Multi-cycle MIPS control unit: steps FETCH->DECODE->EXEC->MEM->WB and drives
// datapath strobes from the current state plus the registered instruction class.
module mc_control #(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit SUPPORT_EXT   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] npcsel,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] EXTop,
  output logic [1:0] ALUctr,
  output logic [2:0] state,
  output logic       illegal
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3, S_WB = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    C_NOP, C_ADDU, C_SUBU, C_JR, C_ORI, C_LUI, C_ADDIU,
    C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JAL, C_ILL
  } cls_e;

  state_e state_q, state_d;
  cls_e   cls_q, cls_dec, cls;
  logic   rdy;

  assign rdy   = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state = state_q;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    cls_dec = C_ILL;
    case (op)
      6'b000000: begin
        case (func)
          6'b000000: cls_dec = C_NOP;
          6'b100001: cls_dec = C_ADDU;
          6'b100011: cls_dec = C_SUBU;
          6'b001000: cls_dec = C_JR;
          default:   cls_dec = C_ILL;
        endcase
      end
      6'b001101: cls_dec = C_ORI;
      6'b001111: cls_dec = C_LUI;
      6'b100011: cls_dec = C_LW;
      6'b101011: cls_dec = C_SW;
      6'b000100: cls_dec = C_BEQ;
      6'b000011: cls_dec = C_JAL;
      6'b001001: cls_dec = SUPPORT_EXT ? C_ADDIU : C_ILL;
      6'b000101: cls_dec = SUPPORT_EXT ? C_BNE   : C_ILL;
      6'b000010: cls_dec = SUPPORT_EXT ? C_J     : C_ILL;
      default:   cls_dec = C_ILL;
    endcase
  end

  // The class register only loads at the end of DECODE, so DECODE itself uses the live decode.
  assign cls = (state_q == S_DECODE) ? cls_dec : cls_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (rdy) state_d = S_DECODE;
      S_DECODE: begin
        case (cls_dec)
          C_NOP, C_JR, C_J, C_JAL, C_ILL: state_d = S_FETCH;
          default:                        state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          C_BEQ, C_BNE: state_d = S_FETCH;
          C_LW, C_SW:   state_d = S_MEM;
          default:      state_d = S_WB;
        endcase
      end
      S_MEM:    if (rdy) state_d = (cls_q == C_SW) ? S_FETCH : S_WB;
      default:  state_d = S_FETCH;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      cls_q   <= C_NOP;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= cls_dec;
    end
  end

  always_comb begin
    RegDst   = 2'b00;
    ALUSrc   = 1'b0;
    MemtoReg = 2'b00;
    EXTop    = 2'b00;
    ALUctr   = 2'b00;
    case (cls)
      C_ADDU:              RegDst = 2'b01;
      C_SUBU:              begin RegDst = 2'b01; ALUctr = 2'b01; end
      C_ORI:               begin ALUSrc = 1'b1; ALUctr = 2'b10; end
      C_LUI:               begin ALUSrc = 1'b1; EXTop = 2'b10; end
      C_ADDIU, C_SW:       begin ALUSrc = 1'b1; EXTop = 2'b01; end
      C_LW:                begin ALUSrc = 1'b1; EXTop = 2'b01; MemtoReg = 2'b01; end
      C_BEQ, C_BNE:        ALUctr = 2'b01;
      C_JAL:               begin RegDst = 2'b10; MemtoReg = 2'b10; end
      default:             ;
    endcase
  end

  // Strobes are gated by reset directly: the state register only clears on the next edge.
  always_comb begin
    mem_req  = 1'b0;
    ir_we    = 1'b0;
    pc_we    = 1'b0;
    npcsel   = 2'b00;
    RegWrite = 1'b0;
    MemWrite = 1'b0;
    illegal  = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req = 1'b1;
          ir_we   = rdy;
          pc_we   = rdy;
        end
        S_DECODE: begin
          case (cls_dec)
            C_JAL:   begin RegWrite = 1'b1; pc_we = 1'b1; npcsel = 2'b10; end
            C_J:     begin pc_we = 1'b1; npcsel = 2'b10; end
            C_JR:    begin pc_we = 1'b1; npcsel = 2'b11; end
            C_ILL:   illegal = 1'b1;
            default: ;
          endcase
        end
        S_EXEC: begin
          if (cls_q == C_BEQ)      begin pc_we = zero;  npcsel = 2'b01; end
          else if (cls_q == C_BNE) begin pc_we = ~zero; npcsel = 2'b01; end
        end
        S_MEM: begin
          mem_req  = 1'b1;
          MemWrite = (cls_q == C_SW);
        end
        S_WB:    RegWrite = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: each instruction is expanded from its phase
// path (e.g. "FDEMW") with memory waits, and every cycle is compared to that model.
module tb_mc_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0, func = '0;
  logic       zero = 1'b0, mem_ready = 1'b0;

  logic       mem_req, ir_we, pc_we, RegWrite, MemWrite, ALUSrc, illegal;
  logic [1:0] npcsel, RegDst, MemtoReg, EXTop, ALUctr;
  logic [2:0] state;

  logic       n_mem_req, n_ir_we, n_pc_we, n_RegWrite, n_MemWrite, n_ALUSrc, n_illegal;
  logic [1:0] n_npcsel, n_RegDst, n_MemtoReg, n_EXTop, n_ALUctr;
  logic [2:0] n_state;

  mc_control u_dut (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .ir_we(ir_we), .pc_we(pc_we), .npcsel(npcsel), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .EXTop(EXTop), .ALUctr(ALUctr), .state(state), .illegal(illegal)
  );

  mc_control #(.MEM_HANDSHAKE(1'b1), .SUPPORT_EXT(1'b0)) u_noext (
    .clk(clk), .reset(reset), .op(op), .func(func), .zero(zero), .mem_ready(mem_ready),
    .mem_req(n_mem_req), .ir_we(n_ir_we), .pc_we(n_pc_we), .npcsel(n_npcsel),
    .RegDst(n_RegDst), .ALUSrc(n_ALUSrc), .MemtoReg(n_MemtoReg), .RegWrite(n_RegWrite),
    .MemWrite(n_MemWrite), .EXTop(n_EXTop), .ALUctr(n_ALUctr), .state(n_state),
    .illegal(n_illegal)
  );

  always #5 clk = ~clk;

  // {state, mem_req, ir_we, pc_we, RegWrite, MemWrite, illegal, npcsel, RegDst, ALUSrc, MemtoReg, EXTop, ALUctr}
  logic [19:0] obs, n_obs;
  assign obs   = {state, mem_req, ir_we, pc_we, RegWrite, MemWrite, illegal,
                  npcsel, RegDst, ALUSrc, MemtoReg, EXTop, ALUctr};
  assign n_obs = {n_state, n_mem_req, n_ir_we, n_pc_we, n_RegWrite, n_MemWrite, n_illegal,
                  n_npcsel, n_RegDst, n_ALUSrc, n_MemtoReg, n_EXTop, n_ALUctr};

  localparam logic [19:0] M_STATE  = 20'hE0000;
  localparam logic [19:0] M_STROBE = 20'h1F800;
  localparam logic [19:0] M_NPC    = 20'h00600;
  localparam logic [19:0] M_FIELDS = 20'h001FF;

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] func;
    bit         rtype;
    string      path;
    logic [8:0] fields;   // {RegDst, ALUSrc, MemtoReg, EXTop, ALUctr}
  } ref_t;

  localparam int I_ADDU = 0, I_SUBU = 1, I_ORI = 2, I_LUI = 3, I_ADDIU = 4, I_LW = 5,
                 I_SW = 6, I_BEQ = 7, I_BNE = 8, I_J = 9, I_JAL = 10, I_JR = 11,
                 I_NOP = 12, I_ILL_OP = 13, I_ILL_FN = 14, N_REF = 15;

  ref_t tbl [N_REF];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string tag, input logic [19:0] o, input logic [19:0] e,
                       input logic [19:0] m);
    n_tests++;
    assert ((o & m) === (e & m)) else begin
      n_fail++;
      $error("FAIL %s: observed %05h required %05h (mask %05h)", tag, o & m, e & m, m);
    end
  endtask

  task automatic set_ref(input int i, input string nm, input logic [5:0] o, input logic [5:0] f,
                         input bit rt, input string p, input logic [1:0] rd, input logic as,
                         input logic [1:0] mr, input logic [1:0] ex, input logic [1:0] ac);
    tbl[i].name   = nm;
    tbl[i].op     = o;
    tbl[i].func   = f;
    tbl[i].rtype  = rt;
    tbl[i].path   = p;
    tbl[i].fields = {rd, as, mr, ex, ac};
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      mem_ready = 1'($urandom);
      op        = 6'($urandom);
      @(negedge clk);
      check($sformatf("reset_strobes%0d", c), obs, 20'h0, M_STROBE);
      @(posedge clk); #1;
    end
    reset     = 1'b0;
    mem_ready = 1'b0;
    @(negedge clk);
    check("reset_release", obs, {3'd0, 6'b100000, 11'd0}, M_STATE | M_STROBE);
    @(posedge clk); #1;
  endtask

  // Runs one instruction starting in FETCH; rst_mem >= 0 asserts reset on that MEM wait cycle.
  task automatic run_instr(input int idx, input int fw, input int mw, input logic z,
                           input bit chk_noext, input int rst_mem);
    ref_t r;
    r    = tbl[idx];
    op   = r.op;
    func = r.rtype ? r.func : 6'($urandom);
    zero = z;
    for (int p = 0; p < r.path.len(); p++) begin
      byte ph;
      int  reps;
      ph   = r.path[p];
      reps = (ph == "F") ? fw + 1 : (ph == "M") ? mw + 1 : 1;
      for (int k = 0; k < reps; k++) begin
        logic [19:0] e, m;
        bit last, inj;
        last = (k == reps - 1);
        inj  = (ph == "M") && (k == rst_mem);
        e = '0;
        m = M_STATE | M_STROBE;
        mem_ready = (ph == "F" || ph == "M") ? (last && !inj) : 1'($urandom);
        if (ph != "F") begin
          e[8:0] = r.fields;
          m |= M_FIELDS;
        end
        case (ph)
          "F": begin
            e[19:17] = 3'd0; e[16] = 1'b1; e[15] = last; e[14] = last;
            if (last) m |= M_NPC;
          end
          "D": begin
            e[19:17] = 3'd1;
            if (idx == I_JAL) begin e[13] = 1'b1; e[14] = 1'b1; e[10:9] = 2'b10; m |= M_NPC; end
            if (idx == I_J)   begin e[14] = 1'b1; e[10:9] = 2'b10; m |= M_NPC; end
            if (idx == I_JR)  begin e[14] = 1'b1; e[10:9] = 2'b11; m |= M_NPC; end
            if (idx == I_ILL_OP || idx == I_ILL_FN) e[11] = 1'b1;
          end
          "E": begin
            e[19:17] = 3'd2;
            if (idx == I_BEQ) begin e[14] = z;  e[10:9] = 2'b01; m |= M_NPC; end
            if (idx == I_BNE) begin e[14] = ~z; e[10:9] = 2'b01; m |= M_NPC; end
          end
          "M": begin
            e[19:17] = 3'd3; e[16] = 1'b1; e[12] = (idx == I_SW);
          end
          default: begin
            e[19:17] = 3'd4; e[13] = 1'b1;
          end
        endcase
        if (inj) begin
          reset = 1'b1;
          e[16:11] = '0;
        end
        @(negedge clk);
        check($sformatf("%s_%c%0d", r.name, ph, k), obs, e, m);
        if (chk_noext && ph == "D")
          check("noext_illegal_decode", n_obs, {3'd1, 6'b000001, 11'd0}, M_STATE | M_STROBE);
        if (chk_noext && ph == "E")
          check("noext_back_fetch", n_obs, {3'd0, 6'b100000, 11'd0}, M_STATE | M_STROBE);
        @(posedge clk); #1;
        if (inj) begin
          reset     = 1'b0;
          mem_ready = 1'b0;
          @(negedge clk);
          check("reset_mid_mem", obs, {3'd0, 6'b100000, 11'd0}, M_STATE | M_STROBE);
          @(posedge clk); #1;
          return;
        end
      end
    end
  endtask

  initial begin
    set_ref(I_ADDU,   "addu",   6'b000000, 6'b100001, 1, "FDEW",  2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    set_ref(I_SUBU,   "subu",   6'b000000, 6'b100011, 1, "FDEW",  2'b01, 1'b0, 2'b00, 2'b00, 2'b01);
    set_ref(I_ORI,    "ori",    6'b001101, 6'b000000, 0, "FDEW",  2'b00, 1'b1, 2'b00, 2'b00, 2'b10);
    set_ref(I_LUI,    "lui",    6'b001111, 6'b000000, 0, "FDEW",  2'b00, 1'b1, 2'b00, 2'b10, 2'b00);
    set_ref(I_ADDIU,  "addiu",  6'b001001, 6'b000000, 0, "FDEW",  2'b00, 1'b1, 2'b00, 2'b01, 2'b00);
    set_ref(I_LW,     "lw",     6'b100011, 6'b000000, 0, "FDEMW", 2'b00, 1'b1, 2'b01, 2'b01, 2'b00);
    set_ref(I_SW,     "sw",     6'b101011, 6'b000000, 0, "FDEM",  2'b00, 1'b1, 2'b00, 2'b01, 2'b00);
    set_ref(I_BEQ,    "beq",    6'b000100, 6'b000000, 0, "FDE",   2'b00, 1'b0, 2'b00, 2'b00, 2'b01);
    set_ref(I_BNE,    "bne",    6'b000101, 6'b000000, 0, "FDE",   2'b00, 1'b0, 2'b00, 2'b00, 2'b01);
    set_ref(I_J,      "j",      6'b000010, 6'b000000, 0, "FD",    2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    set_ref(I_JAL,    "jal",    6'b000011, 6'b000000, 0, "FD",    2'b10, 1'b0, 2'b10, 2'b00, 2'b00);
    set_ref(I_JR,     "jr",     6'b000000, 6'b001000, 1, "FD",    2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    set_ref(I_NOP,    "nop",    6'b000000, 6'b000000, 1, "FD",    2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    set_ref(I_ILL_OP, "ill_op", 6'b111111, 6'b000000, 0, "FD",    2'b00, 1'b0, 2'b00, 2'b00, 2'b00);
    set_ref(I_ILL_FN, "ill_fn", 6'b000000, 6'b100000, 1, "FD",    2'b00, 1'b0, 2'b00, 2'b00, 2'b00);

    do_reset(2);
    run_instr(I_ADDU, 0, 0, 1'b0, 1'b0, -1);
    run_instr(I_LW,   0, 3, 1'b0, 1'b0, -1);
    run_instr(I_BEQ,  0, 0, 1'b1, 1'b0, -1);
    run_instr(I_BEQ,  0, 0, 1'b0, 1'b0, -1);
    run_instr(I_JAL,  0, 0, 1'b0, 1'b0, -1);
    run_instr(I_SW,   2, 2, 1'b0, 1'b0, -1);

    do_reset(1);
    run_instr(I_ADDIU, 0, 0, 1'b0, 1'b1, -1);
    run_instr(I_SW,    1, 5, 1'b0, 1'b0, 2);

    for (int t = 0; t < 120; t++) begin
      run_instr($urandom_range(0, N_REF - 1), $urandom_range(0, 2), $urandom_range(0, 3),
                1'($urandom), 1'b0, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
